// File: rtl/req_collector.sv
// Request collector: captures per-source request events into sticky pending bits,
// masks them for the downstream encoder, raises irq and retires one bit per acknowledge.
module req_collector #(
    parameter int IP_WIDTH  = 4,
    parameter int EDGE_MODE = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [IP_WIDTH-1:0]           req_i,
    input  logic [IP_WIDTH-1:0]           mask_i,
    input  logic                          ack_i,
    input  logic [$clog2(IP_WIDTH)-1:0]   ack_idx_i,
    input  logic                          ovf_clr_i,
    output logic [IP_WIDTH-1:0]           pend_vec_o,
    output logic [$clog2(IP_WIDTH):0]     pend_cnt_o,
    output logic                          irq_o,
    output logic [IP_WIDTH-1:0]           ovf_o,
    output logic                          ack_err_o
);

    localparam int IDX_W = $clog2(IP_WIDTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [IP_WIDTH-1:0] req_q;
    logic [IP_WIDTH-1:0] pend_q;
    logic [IP_WIDTH-1:0] pend_d;
    logic [IP_WIDTH-1:0] ovf_q;
    logic [IP_WIDTH-1:0] ovf_d;
    logic                ack_err_q;
    logic                ack_err_d;
    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic                irq_q;
    logic                irq_d;

    logic [IP_WIDTH-1:0] ev_s;
    logic [IP_WIDTH-1:0] ack_sel_s;
    logic [IP_WIDTH-1:0] clr_s;
    logic [IP_WIDTH-1:0] ovf_set_s;
    logic                ack_hit_s;
    logic                ack_ok_s;
    logic                err_set_s;
    logic                any_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [IP_WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < IP_WIDTH; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Out-of-range indices (non power-of-two widths) decode to no bit at all.
    function automatic logic [IP_WIDTH-1:0] ack_decode(input logic [IDX_W-1:0] idx);
        logic [IP_WIDTH-1:0] sel;
        sel = {IP_WIDTH{1'b0}};
        for (int i = 0; i < IP_WIDTH; i++) begin
            sel[i] = (idx == IDX_W'(i));
        end
        return sel;
    endfunction

    assign pend_vec_o = pend_q & ~mask_i;
    assign pend_cnt_o = popcount(pend_vec_o);
    assign irq_o      = irq_q;
    assign ovf_o      = ovf_q;
    assign ack_err_o  = ack_err_q;

    // Event detection: rising edge or level, selected at elaboration.
    always_comb begin
        ev_s = {IP_WIDTH{1'b0}};
        if (EDGE_MODE != 0) begin
            ev_s = req_i & ~req_q;
        end else begin
            ev_s = req_i;
        end
    end

    // Acknowledge qualification and pending/overflow/error next state.
    always_comb begin
        ack_sel_s = ack_decode(ack_idx_i);
        ack_hit_s = |(ack_sel_s & pend_vec_o);
        ack_ok_s  = ack_i & (state_q == ST_PEND) & ack_hit_s;
        err_set_s = ack_i & ~ack_ok_s;
        if (ack_ok_s) begin
            clr_s = ack_sel_s;
        end else begin
            clr_s = {IP_WIDTH{1'b0}};
        end
        // A coincident event keeps the bit set and is not an overflow.
        pend_d    = ev_s | (pend_q & ~clr_s);
        ovf_set_s = ev_s & pend_q & ~clr_s;
        if (ovf_clr_i) begin
            ovf_d     = ovf_set_s;
            ack_err_d = err_set_s;
        end else begin
            ovf_d     = ovf_q | ovf_set_s;
            ack_err_d = ack_err_q | err_set_s;
        end
    end

    // Service FSM; any looks at the current pend register, so irq trails pend_vec by a cycle.
    always_comb begin
        any_s   = |pend_vec_o;
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (ack_ok_s) begin
                    state_d = ST_HOLD;
                end else if (any_s) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (any_s) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        irq_d = (state_d == ST_PEND);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q     <= {IP_WIDTH{1'b0}};
            pend_q    <= {IP_WIDTH{1'b0}};
            ovf_q     <= {IP_WIDTH{1'b0}};
            ack_err_q <= 1'b0;
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
        end else begin
            req_q     <= req_i;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            ack_err_q <= ack_err_d;
            state_q   <= state_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_req_collector.sv
// Bench for req_collector: edge- and level-mode instances share stimulus; a reference
// model pushes expected outputs per cycle, popped and compared after each clock edge.
module tb_req_collector;

    typedef struct packed {
        logic [3:0] req_q;
        logic [3:0] pend;
        logic [3:0] ovf;
        logic       err;
        logic [1:0] state;
    } model_t;

    typedef struct packed {
        logic [3:0] pvec;
        logic [2:0] cnt;
        logic       irq;
        logic [3:0] ovf;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'd0;
    logic [3:0] mask = 4'd0;
    logic       ack = 1'b0;
    logic [1:0] ack_idx = 2'd0;
    logic       ovf_clr = 1'b0;

    logic [3:0] pv_e, pv_l, ovf_e, ovf_l;
    logic [2:0] cnt_e, cnt_l;
    logic       irq_e, irq_l, err_e, err_l;

    model_t m_e = '0;
    model_t m_l = '0;
    exp_t   q_e[$];
    exp_t   q_l[$];
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;

    req_collector #(.IP_WIDTH(4), .EDGE_MODE(1)) dut_e (
        .clk_i(clk), .rst_i(rst), .req_i(req), .mask_i(mask), .ack_i(ack),
        .ack_idx_i(ack_idx), .ovf_clr_i(ovf_clr), .pend_vec_o(pv_e),
        .pend_cnt_o(cnt_e), .irq_o(irq_e), .ovf_o(ovf_e), .ack_err_o(err_e)
    );

    req_collector #(.IP_WIDTH(4), .EDGE_MODE(0)) dut_l (
        .clk_i(clk), .rst_i(rst), .req_i(req), .mask_i(mask), .ack_i(ack),
        .ack_idx_i(ack_idx), .ovf_clr_i(ovf_clr), .pend_vec_o(pv_l),
        .pend_cnt_o(cnt_l), .irq_o(irq_l), .ovf_o(ovf_l), .ack_err_o(err_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] ones(input logic [3:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 4; i++) c = c + {2'b00, v[i]};
        return c;
    endfunction

    function automatic model_t model_next(input model_t s, input bit edge_mode);
        model_t     n;
        logic [3:0] ev, pv, clr;
        logic       valid, any;
        ev    = edge_mode ? (req & ~s.req_q) : req;
        pv    = s.pend & ~mask;
        valid = ack && (s.state == 2'd1) && pv[ack_idx];
        clr   = valid ? (4'b0001 << ack_idx) : 4'b0000;
        any   = (pv != 4'b0000);
        n.req_q = req;
        n.pend  = ev | (s.pend & ~clr);
        n.ovf   = (ovf_clr ? 4'b0000 : s.ovf) | (ev & s.pend & ~clr);
        n.err   = (ovf_clr ? 1'b0 : s.err) | (ack && !valid);
        case (s.state)
            2'd1:    n.state = valid ? 2'd2 : (any ? 2'd1 : 2'd0);
            default: n.state = any ? 2'd1 : 2'd0;
        endcase
        return n;
    endfunction

    function automatic exp_t expect_of(input model_t s);
        exp_t e;
        e.pvec = s.pend & ~mask;
        e.cnt  = ones(e.pvec);
        e.irq  = (s.state == 2'd1);
        e.ovf  = s.ovf;
        e.err  = s.err;
        return e;
    endfunction

    // One clock: predict, push, clock, then pop and compare both instances.
    task automatic step();
        exp_t e;
        m_e = model_next(m_e, 1'b1);
        m_l = model_next(m_l, 1'b0);
        q_e.push_back(expect_of(m_e));
        q_l.push_back(expect_of(m_l));
        @(posedge clk);
        #1;
        e = q_e.pop_front();
        check("e.pvec", 32'(pv_e), 32'(e.pvec));
        check("e.cnt", 32'(cnt_e), 32'(e.cnt));
        check("e.irq", 32'(irq_e), 32'(e.irq));
        check("e.ovf", 32'(ovf_e), 32'(e.ovf));
        check("e.err", 32'(err_e), 32'(e.err));
        e = q_l.pop_front();
        check("l.pvec", 32'(pv_l), 32'(e.pvec));
        check("l.cnt", 32'(cnt_l), 32'(e.cnt));
        check("l.irq", 32'(irq_l), 32'(e.irq));
        check("l.ovf", 32'(ovf_l), 32'(e.ovf));
        check("l.err", 32'(err_l), 32'(e.err));
    endtask

    task automatic do_ack(input logic [1:0] idx);
        ack = 1'b1; ack_idx = idx; step();
        ack = 1'b0; step();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.pvec", 32'(pv_e), 32'd0);
        check("rst.cnt", 32'(cnt_e), 32'd0);
        check("rst.irq", 32'(irq_e), 32'd0);
        check("rst.ovf", 32'(ovf_e), 32'd0);

        // Single pulse on source 2, then acknowledge it.
        req = 4'b0100; step();
        check("p2.pvec", 32'(pv_e), 32'h4);
        check("p2.cnt", 32'(cnt_e), 32'd1);
        check("p2.irq_early", 32'(irq_e), 32'd0);
        req = 4'b0000; step();
        check("p2.irq", 32'(irq_e), 32'd1);
        ack = 1'b1; ack_idx = 2'd2; step();
        check("ack2.pvec", 32'(pv_e), 32'd0);
        check("ack2.irq", 32'(irq_e), 32'd0);
        ack = 1'b0; step();
        check("ack2.idle", 32'(irq_e), 32'd0);

        // Two sources at once, serviced back to back.
        req = 4'b1010; step();
        check("two.cnt", 32'(cnt_e), 32'd2);
        req = 4'b0000; step();
        ack = 1'b1; ack_idx = 2'd3; step();
        check("ack3.pvec", 32'(pv_e), 32'h2);
        check("ack3.gap", 32'(irq_e), 32'd0);
        ack = 1'b0; step();
        check("ack3.rearm", 32'(irq_e), 32'd1);
        ack = 1'b1; ack_idx = 2'd1; step();
        ack = 1'b0; step();
        check("ack1.irq", 32'(irq_e), 32'd0);

        // Overflow, clear, and set-wins against a coincident acknowledge.
        req = 4'b0001; step();
        req = 4'b0000; step();
        req = 4'b0001; step();
        check("ovf.set", 32'(ovf_e), 32'h1);
        check("ovf.pend0", 32'(pv_e[0]), 32'd1);
        req = 4'b0000; ovf_clr = 1'b1; step();
        check("ovf.clr", 32'(ovf_e), 32'd0);
        ovf_clr = 1'b0;
        req = 4'b0001; ack = 1'b1; ack_idx = 2'd0; step();
        check("setwin.pend0", 32'(pv_e[0]), 32'd1);
        check("setwin.ovf", 32'(ovf_e), 32'd0);
        req = 4'b0000; ack = 1'b0; step();
        do_ack(2'd0);

        // Fully masked source stays hidden until the mask drops.
        mask = 4'b1111; req = 4'b0010; step();
        check("mask.pvec", 32'(pv_e), 32'd0);
        req = 4'b0000; step();
        check("mask.irq", 32'(irq_e), 32'd0);
        mask = 4'b0000;
        #1;
        check("mask.comb", 32'(pv_e), 32'h2);
        step();
        check("unmask.irq", 32'(irq_e), 32'd1);
        do_ack(2'd1);

        // Illegal acknowledges: wrong index in PEND, and any ack in IDLE.
        req = 4'b0100; step();
        req = 4'b0000; step();
        ack = 1'b1; ack_idx = 2'd0; step();
        check("err.pend", 32'(err_e), 32'd1);
        check("err.keep", 32'(pv_e), 32'h4);
        ack = 1'b0; ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;
        do_ack(2'd2);
        ack = 1'b1; ack_idx = 2'd2; step();
        check("err.idle", 32'(err_e), 32'd1);
        ack = 1'b0; ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;

        // Asynchronous reset while in PEND with two bits pending.
        req = 4'b0110; step();
        req = 4'b0000; step();
        check("pre_rst.pvec", 32'(pv_e), 32'h6);
        #2;
        rst = 1'b1;
        #1;
        check("arst.e.pvec", 32'(pv_e), 32'd0);
        check("arst.e.cnt", 32'(cnt_e), 32'd0);
        check("arst.e.irq", 32'(irq_e), 32'd0);
        check("arst.l.pvec", 32'(pv_l), 32'd0);
        check("arst.l.irq", 32'(irq_l), 32'd0);
        m_e = '0;
        m_l = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Level mode: a held line keeps its bit pending across each acknowledge.
        req = 4'b1000; step();
        check("lvl.pvec", 32'(pv_l), 32'h8);
        step();
        check("lvl.irq", 32'(irq_l), 32'd1);
        check("lvl.ovf", 32'(ovf_l), 32'h8);
        ack = 1'b1; ack_idx = 2'd3; step();
        check("lvl.repend", 32'(pv_l), 32'h8);
        check("lvl.gap", 32'(irq_l), 32'd0);
        ack = 1'b0; step();
        check("lvl.rearm", 32'(irq_l), 32'd1);
        req = 4'b0000; step();
        do_ack(2'd3);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
